// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions for the memory stage: FSM states, the
// M-stage control bundle, the default memory timeout and the alignment check.
package mem_stage_ctrl_pkg;

  // Memory-access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Control bits carried by the E/M register
  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemWrite;
  } ctrl_t;

  // REQ-state cycles allowed without ack before the access is abandoned
  localparam int unsigned DEFAULT_TIMEOUT = 32'd255;

  // Word accesses must have both low address bits clear
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/flopenr_mw.sv
// M/W pipeline register with asynchronous active-high reset.
// bubble_i squashes the writeback controls so the W stage sees a no-op;
// rd_en_i restricts updates of the read-data field to completed accesses.
module flopenr_mw (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble_i,
  input  logic        rd_en_i,
  input  logic [31:0] rd_i,
  input  logic [31:0] alu_i,
  input  logic [3:0]  wa3_i,
  input  logic        regwrite_i,
  input  logic        memtoreg_i,
  output logic [31:0] rd_o,
  output logic [31:0] alu_o,
  output logic [3:0]  wa3_o,
  output logic        regwrite_o,
  output logic        memtoreg_o
);

  logic        regwrite_d;
  logic        memtoreg_d;
  logic [31:0] rd_d;
  logic [31:0] rd_q;
  logic [31:0] alu_q;
  logic [3:0]  wa3_q;
  logic        regwrite_q;
  logic        memtoreg_q;

  // Next-state of the register: bubble forces the controls low, read data holds unless enabled
  always_comb begin
    regwrite_d = regwrite_i;
    memtoreg_d = memtoreg_i;
    rd_d       = rd_q;
    if (bubble_i) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else begin
      regwrite_d = regwrite_i;
      memtoreg_d = memtoreg_i;
    end
    if (rd_en_i) begin
      rd_d = rd_i;
    end else begin
      rd_d = rd_q;
    end
  end

  // M/W storage, cleared asynchronously on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q       <= 32'h0000_0000;
      alu_q      <= 32'h0000_0000;
      wa3_q      <= 4'h0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      rd_q       <= rd_d;
      alu_q      <= alu_i;
      wa3_q      <= wa3_i;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  assign rd_o       = rd_q;
  assign alu_o      = alu_q;
  assign wa3_o      = wa3_q;
  assign regwrite_o = regwrite_q;
  assign memtoreg_o = memtoreg_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller. Issues one load/store at a time to a multi-cycle
// data memory over req/ack, stalls the front of the pipeline while the access
// is outstanding, and turns misaligned addresses and timeouts into a
// suppressed writeback plus a one-cycle fault pulse.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        dmem_fault,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic        RegWriteW,
  output logic        MemtoRegW
);

  // Counter must be able to hold the value TIMEOUT itself
  localparam int CW = $clog2(TIMEOUT + 32'd1);

  state_e      state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic        suppress_q;
  logic [31:0] hold_q;
  logic [CW-1:0] cnt_q;

  ctrl_t ctrl_s;
  logic  memop_s;
  logic  misalign_s;
  logic  start_s;
  logic  last_wait_s;
  logic  mw_bubble_s;
  logic  mw_rd_en_s;

  assign ctrl_s      = '{RegWrite: RegWriteM, MemtoReg: MemtoRegM, MemWrite: MemWriteM};
  assign memop_s     = ctrl_s.MemtoReg | ctrl_s.MemWrite;
  assign misalign_s  = memop_s & is_misaligned(ALUOutM[1:0]);
  assign start_s     = (state_q == IDLE) & memop_s & ~misalign_s;
  // Final permitted REQ cycle: the counter has already seen TIMEOUT-1 waits
  assign last_wait_s = (cnt_q == CW'(TIMEOUT - 32'd1));

  // Stall while an aligned access is being launched or is outstanding
  assign StallM = start_s | (state_q == REQ);

  // Decide what the M/W register loads this cycle
  always_comb begin
    mw_bubble_s = 1'b1;
    mw_rd_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        // Any memop leaving IDLE is either faulted or still in flight
        mw_bubble_s = memop_s;
        mw_rd_en_s  = 1'b0;
      end
      REQ: begin
        mw_bubble_s = 1'b1;
        mw_rd_en_s  = 1'b0;
      end
      DONE: begin
        mw_bubble_s = suppress_q;
        mw_rd_en_s  = 1'b1;
      end
      default: begin
        mw_bubble_s = 1'b1;
        mw_rd_en_s  = 1'b0;
      end
    endcase
  end

  // Access FSM with its request, hold, counter and fault registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      fault_q    <= 1'b0;
      suppress_q <= 1'b0;
      hold_q     <= 32'h0000_0000;
      cnt_q      <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          fault_q <= misalign_s;
          if (start_s) begin
            addr_q  <= ALUOutM;
            wdata_q <= WriteDataM;
            we_q    <= ctrl_s.MemWrite;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= REQ;
          end else begin
            state_q <= IDLE;
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CW'(1);
          if (dmem_ack) begin
            // An ack on the last permitted cycle still completes normally
            hold_q  <= dmem_rdata;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (last_wait_s) begin
            req_q      <= 1'b0;
            fault_q    <= 1'b1;
            suppress_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            state_q <= REQ;
          end
        end
        DONE: begin
          cnt_q      <= '0;
          suppress_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_fault = fault_q;

  flopenr_mw u_mw (
    .clk        (clk),
    .reset      (reset),
    .bubble_i   (mw_bubble_s),
    .rd_en_i    (mw_rd_en_s),
    .rd_i       (hold_q),
    .alu_i      (ALUOutM),
    .wa3_i      (WA3M),
    .regwrite_i (RegWriteM),
    .memtoreg_i (MemtoRegM),
    .rd_o       (ReadDataW),
    .alu_o      (ALUOutW),
    .wa3_o      (WA3W),
    .regwrite_o (RegWriteW),
    .memtoreg_o (MemtoRegW)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a short timeout so the abandon path
// is reachable quickly.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [3:0]  WA3M;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic        MemWriteM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        StallM;
  logic        dmem_fault;
  logic [31:0] ReadDataW;
  logic [31:0] ALUOutW;
  logic [3:0]  WA3W;
  logic        RegWriteW;
  logic        MemtoRegW;

  int total;
  int bad;

  // Per-operation observations
  int          stall_n;
  int          req_n;
  int          fault_n;
  int          stab_bad;
  logic        done_seen;
  logic [31:0] w_rd;
  logic [31:0] w_alu;
  logic [3:0]  w_wa3;
  logic        w_rw;
  logic        w_m2r;

  mem_stage_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .WA3M       (WA3M),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .StallM     (StallM),
    .dmem_fault (dmem_fault),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WA3W       (WA3W),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_nop();
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;
    WA3M       = 4'h0;
    RegWriteM  = 1'b0;
    MemtoRegM  = 1'b0;
    MemWriteM  = 1'b0;
  endtask

  // Present one instruction in M, answer the memory after ack_dly wait cycles
  // (or never), and record stall/req/fault counts plus the W result.
  task automatic do_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wa,
                       input logic rw, input logic m2r, input logic mw,
                       input int ack_dly, input logic give_ack, input logic [31:0] rdata);
    @(negedge clk);
    ALUOutM = a; WriteDataM = wd; WA3M = wa;
    RegWriteM = rw; MemtoRegM = m2r; MemWriteM = mw;
    dmem_rdata = rdata;
    dmem_ack = 1'b0;
    stall_n = 0; req_n = 0; fault_n = 0; stab_bad = 0; done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (StallM) stall_n++;
      if (dmem_fault) fault_n++;
      if (dmem_req) begin
        req_n++;
        if (dmem_addr !== a || dmem_wdata !== wd || dmem_we !== mw) stab_bad++;
      end
      if (!StallM) begin
        done_seen = 1'b1;
        break;
      end
      dmem_ack = give_ack && dmem_req && (req_n == ack_dly + 1);
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    if (!done_seen) check_val("op_completes", 32'd0, 32'd1);
    @(negedge clk);
    #1;
    w_rd = ReadDataW; w_alu = ALUOutW; w_wa3 = WA3W; w_rw = RegWriteW; w_m2r = MemtoRegW;
    if (dmem_fault) fault_n++;
    if (dmem_req) req_n++;
    drive_nop();
    @(negedge clk);
    #1;
    if (dmem_fault) fault_n++;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    drive_nop();
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_req",   {31'd0, dmem_req},   32'd0);
    check_val("rst_we",    {31'd0, dmem_we},    32'd0);
    check_val("rst_addr",  dmem_addr,           32'd0);
    check_val("rst_wdata", dmem_wdata,          32'd0);
    check_val("rst_fault", {31'd0, dmem_fault}, 32'd0);
    check_val("rst_stall", {31'd0, StallM},     32'd0);
    check_val("rst_rdw",   ReadDataW,           32'd0);
    check_val("rst_aluw",  ALUOutW,             32'd0);
    check_val("rst_ctlw",  {27'd0, WA3W, RegWriteW, MemtoRegW}, 32'd0);
    reset = 1'b0;

    // ALU result flows straight through
    do_op(32'h0000_0010, 32'h0, 4'd3, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    check_val("add_stall", stall_n, 32'd0);
    check_val("add_req",   req_n,   32'd0);
    check_val("add_aluw",  w_alu,   32'h10);
    check_val("add_wa3w",  {28'd0, w_wa3}, 32'd3);
    check_val("add_rw",    {31'd0, w_rw},  32'd1);
    check_val("add_m2r",   {31'd0, w_m2r}, 32'd0);
    check_val("add_rdw",   w_rd,    32'd0);

    // Load, ack on first REQ cycle
    do_op(32'h0000_0100, 32'h0, 4'd5, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32'hDEAD_BEEF);
    check_val("ld_stall", stall_n, 32'd2);
    check_val("ld_req",   req_n,   32'd1);
    check_val("ld_stab",  stab_bad, 32'd0);
    check_val("ld_fault", fault_n, 32'd0);
    check_val("ld_rdw",   w_rd,    32'hDEAD_BEEF);
    check_val("ld_rw",    {31'd0, w_rw},  32'd1);
    check_val("ld_m2r",   {31'd0, w_m2r}, 32'd1);
    check_val("ld_wa3w",  {28'd0, w_wa3}, 32'd5);

    // Store acked after 3 wait cycles (last permitted REQ cycle)
    do_op(32'h0000_0204, 32'h1234_5678, 4'd0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 32'hCAFE_0001);
    check_val("st_stall", stall_n, 32'd5);
    check_val("st_req",   req_n,   32'd4);
    check_val("st_stab",  stab_bad, 32'd0);
    check_val("st_fault", fault_n, 32'd0);
    check_val("st_rw",    {31'd0, w_rw}, 32'd0);
    check_val("st_rdw",   w_rd,    32'hCAFE_0001);

    // Misaligned load
    do_op(32'h0000_0102, 32'h0, 4'd7, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h5555_5555);
    check_val("mis_stall", stall_n, 32'd0);
    check_val("mis_req",   req_n,   32'd0);
    check_val("mis_fault", fault_n, 32'd1);
    check_val("mis_rw",    {31'd0, w_rw},  32'd0);
    check_val("mis_m2r",   {31'd0, w_m2r}, 32'd0);
    check_val("mis_rdw",   w_rd,    32'hCAFE_0001);

    // Load with no ack: abandoned after 4 REQ cycles
    do_op(32'h0000_0300, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h7777_7777);
    check_val("to_req",   req_n,   32'd4);
    check_val("to_stall", stall_n, 32'd5);
    check_val("to_fault", fault_n, 32'd1);
    check_val("to_rw",    {31'd0, w_rw},  32'd0);
    check_val("to_m2r",   {31'd0, w_m2r}, 32'd0);

    // Back in IDLE: a plain ALU op flows without stalling
    do_op(32'h0000_0044, 32'h0, 4'd2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    check_val("post_to_stall", stall_n, 32'd0);
    check_val("post_to_aluw",  w_alu,   32'h44);
    check_val("post_to_rw",    {31'd0, w_rw}, 32'd1);

    // Reset in the second REQ cycle
    @(negedge clk);
    ALUOutM = 32'h0000_0400; WA3M = 4'd6; RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rr_req_before", {31'd0, dmem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("rr_req",   {31'd0, dmem_req}, 32'd0);
    check_val("rr_addr",  dmem_addr, 32'd0);
    check_val("rr_rdw",   ReadDataW, 32'd0);
    check_val("rr_aluw",  ALUOutW,   32'd0);
    check_val("rr_ctlw",  {27'd0, WA3W, RegWriteW, MemtoRegW}, 32'd0);
    @(negedge clk);
    drive_nop();
    reset = 1'b0;
    do_op(32'h0000_0020, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 32'h0);
    check_val("rr_nop_stall", stall_n, 32'd0);
    check_val("rr_nop_aluw",  w_alu,   32'h20);
    check_val("rr_nop_rw",    {31'd0, w_rw}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
